// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 2RW SRAM model.
package sram_pkg;

  typedef enum logic {CLEAR, RUN} clear_state_t;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 2;

  // Widest word the helper supports; callers cast the result down to DATA_W.
  localparam int unsigned MAX_DATA_W = 1024;
  localparam int unsigned MAX_MASK_W = MAX_DATA_W / 8;

  function automatic bit read_lat_legal(input int unsigned lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

  function automatic logic [MAX_DATA_W-1:0] mask_expand(input logic [MAX_MASK_W-1:0] mask);
    logic [MAX_DATA_W-1:0] bits;
    bits = '0;
    for (int unsigned k = 0; k < MAX_MASK_W; k++) begin
      bits[8*k +: 8] = {8{mask[k]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data/valid latency pipeline for one SRAM port; flushed by reset.
module sram_rd_pipe #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o
);

  logic              v1_q;
  logic [DATA_W-1:0] d1_q;

  // Data registers only load on a valid read so rdata holds between reads.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= rd_en_i;
      if (rd_en_i) d1_q <= rd_data_i;
    end
  end

  if (READ_LAT >= 2) begin : g_lat2
    logic              v2_q;
    logic [DATA_W-1:0] d2_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end

    assign rdata_o  = d2_q;
    assign rvalid_o = v2_q;
  end else begin : g_lat1
    assign rdata_o  = d1_q;
    assign rvalid_o = v1_q;
  end

endmodule

// File: rtl/sram_2rw_param.sv
// Two-port read/write SRAM model: byte-masked writes, read-first, port-1 write
// priority, collision flag and post-reset clear sequencer.
module sram_2rw_param
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned READ_LAT       = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned MASK_W         = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  output logic              ready,
  input  logic              p1_en,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [MASK_W-1:0] p1_wmask,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rvalid,
  input  logic              p2_en,
  input  logic              p2_we,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [MASK_W-1:0] p2_wmask,
  input  logic [DATA_W-1:0] p2_wdata,
  output logic [DATA_W-1:0] p2_rdata,
  output logic              p2_rvalid,
  output logic              collision
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  if (!read_lat_legal(READ_LAT)) begin : g_bad_read_lat
    $error("sram_2rw_param: READ_LAT must be 1 or 2");
  end
  if ((DATA_W % 8) != 0 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $error("sram_2rw_param: DATA_W must be a multiple of 8 within MAX_DATA_W");
  end

  clear_state_t      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              collision_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              acc1, acc2, wr1, wr2, rd1, rd2, same_addr;
  logic [DATA_W-1:0] m1, m2, w2_word, w1_base, w1_word;

  assign ready = (state_q == RUN);

  assign acc1      = p1_en & ready;
  assign acc2      = p2_en & ready;
  assign wr1       = acc1 & p1_we;
  assign wr2       = acc2 & p2_we;
  assign rd1       = acc1 & ~p1_we;
  assign rd2       = acc2 & ~p2_we;
  assign same_addr = (p1_addr == p2_addr);

  assign m1 = DATA_W'(mask_expand(MAX_MASK_W'(p1_wmask)));
  assign m2 = DATA_W'(mask_expand(MAX_MASK_W'(p2_wmask)));

  // Port 1 merges on top of port 2's result so port 1 wins overlapping bytes
  // while port-2-only bytes still land; one array write per address.
  assign w2_word = (mem_q[p2_addr] & ~m2) | (p2_wdata & m2);
  assign w1_base = (wr2 && same_addr) ? w2_word : mem_q[p1_addr];
  assign w1_word = (w1_base & ~m1) | (p1_wdata & m1);

  always_ff @(posedge clock) begin
    if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (wr2 && !(wr1 && same_addr)) mem_q[p2_addr] <= w2_word;
      if (wr1)                        mem_q[p1_addr] <= w1_word;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt_q       <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      collision_q <= acc1 & acc2 & same_addr & (p1_we | p2_we);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign collision = collision_q;

  sram_rd_pipe #(
    .DATA_W  (DATA_W),
    .READ_LAT(READ_LAT)
  ) u_rd_p1 (
    .clock_i  (clock),
    .reset_i  (reset),
    .rd_en_i  (rd1),
    .rd_data_i(mem_q[p1_addr]),
    .rdata_o  (p1_rdata),
    .rvalid_o (p1_rvalid)
  );

  sram_rd_pipe #(
    .DATA_W  (DATA_W),
    .READ_LAT(READ_LAT)
  ) u_rd_p2 (
    .clock_i  (clock),
    .reset_i  (reset),
    .rd_en_i  (rd2),
    .rd_data_i(mem_q[p2_addr]),
    .rdata_o  (p2_rdata),
    .rvalid_o (p2_rvalid)
  );

endmodule

// File: tb/tb_sram_2rw_param.sv
// Scoreboard bench for sram_2rw_param; READ_LAT=1 and READ_LAT=2 instances share stimulus.
module tb_sram_2rw_param;

  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 32;
  localparam int unsigned MW    = 4;
  localparam int unsigned DEPTH = 128;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          p1_en = 1'b0, p2_en = 1'b0, p1_we = 1'b0, p2_we = 1'b0;
  logic [AW-1:0] p1_addr = '0, p2_addr = '0;
  logic [MW-1:0] p1_wmask = '0, p2_wmask = '0;
  logic [DW-1:0] p1_wdata = '0, p2_wdata = '0;

  logic          ready_a, ready_b, coll_a, coll_b;
  logic          rv_a1, rv_a2, rv_b1, rv_b2;
  logic [DW-1:0] rd_a1, rd_a2, rd_b1, rd_b2;

  always #5 clock = ~clock;

  sram_2rw_param #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .CLEAR_ON_RESET(1'b1)) u_dut_l1 (
    .clock(clock), .reset(reset), .ready(ready_a),
    .p1_en(p1_en), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wmask(p1_wmask), .p1_wdata(p1_wdata),
    .p1_rdata(rd_a1), .p1_rvalid(rv_a1),
    .p2_en(p2_en), .p2_we(p2_we), .p2_addr(p2_addr), .p2_wmask(p2_wmask), .p2_wdata(p2_wdata),
    .p2_rdata(rd_a2), .p2_rvalid(rv_a2),
    .collision(coll_a)
  );

  sram_2rw_param #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2), .CLEAR_ON_RESET(1'b1)) u_dut_l2 (
    .clock(clock), .reset(reset), .ready(ready_b),
    .p1_en(p1_en), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wmask(p1_wmask), .p1_wdata(p1_wdata),
    .p1_rdata(rd_b1), .p1_rvalid(rv_b1),
    .p2_en(p2_en), .p2_we(p2_we), .p2_addr(p2_addr), .p2_wmask(p2_wmask), .p2_wdata(p2_wdata),
    .p2_rdata(rd_b2), .p2_rvalid(rv_b2),
    .collision(coll_b)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  // Queues: 0 = L1 port1, 1 = L1 port2, 2 = L2 port1, 3 = L2 port2.
  exp_t        sbq [4][$];
  bit          coll_sched [1024];
  logic [31:0] mdl [DEPTH];
  bit          run_ok = 1'b0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    logic        rv [4];
    logic [31:0] rd [4];
    rv[0] = rv_a1; rv[1] = rv_a2; rv[2] = rv_b1; rv[3] = rv_b2;
    rd[0] = rd_a1; rd[1] = rd_a2; rd[2] = rd_b1; rd[3] = rd_b2;
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        if (sbq[i].size() > 0 && sbq[i][0].due == cyc) begin
          check($sformatf("rvalid[%0d]", i), 32'(rv[i]), 32'd1);
          check($sformatf("rdata[%0d]", i), rd[i], sbq[i][0].data);
          void'(sbq[i].pop_front());
        end else if (rv[i]) begin
          check($sformatf("rvalid_unexpected[%0d]", i), 32'(rv[i]), 32'd0);
        end
      end
      check("collision_l1", 32'(coll_a), 32'(coll_sched[cyc % 1024]));
      check("collision_l2", 32'(coll_b), 32'(coll_sched[cyc % 1024]));
      coll_sched[cyc % 1024] = 1'b0;
    end
  end

  task automatic set_p1(input logic en, input logic we, input logic [AW-1:0] a,
                        input logic [MW-1:0] m, input logic [DW-1:0] d);
    p1_en = en; p1_we = we; p1_addr = a; p1_wmask = m; p1_wdata = d;
  endtask

  task automatic set_p2(input logic en, input logic we, input logic [AW-1:0] a,
                        input logic [MW-1:0] m, input logic [DW-1:0] d);
    p2_en = en; p2_we = we; p2_addr = a; p2_wmask = m; p2_wdata = d;
  endtask

  task automatic idle();
    p1_en = 1'b0;
    p2_en = 1'b0;
  endtask

  // One clock edge: predict reads (pre-write contents), collision, then apply writes.
  task automatic step();
    logic        a1, a2;
    logic [31:0] r1, r2;
    a1 = p1_en && run_ok;
    a2 = p2_en && run_ok;
    r1 = mdl[p1_addr];
    r2 = mdl[p2_addr];
    @(posedge clock);
    #1;
    if (a1 && !p1_we) begin
      sbq[0].push_back('{due: cyc, data: r1});
      sbq[2].push_back('{due: cyc + 1, data: r1});
    end
    if (a2 && !p2_we) begin
      sbq[1].push_back('{due: cyc, data: r2});
      sbq[3].push_back('{due: cyc + 1, data: r2});
    end
    if (a1 && a2 && p1_addr == p2_addr && (p1_we || p2_we)) coll_sched[cyc % 1024] = 1'b1;
    for (int k = 0; k < 4; k++)
      if (a2 && p2_we && p2_wmask[k]) mdl[p2_addr][8*k +: 8] = p2_wdata[8*k +: 8];
    for (int k = 0; k < 4; k++)
      if (a1 && p1_we && p1_wmask[k]) mdl[p1_addr][8*k +: 8] = p1_wdata[8*k +: 8];
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) sbq[i].delete();
    for (int i = 0; i < 1024; i++) coll_sched[i] = 1'b0;
    run_ok = 1'b0;
  endtask

  task automatic reset_checks();
    check("rst_ready_l1", 32'(ready_a), 32'd0);
    check("rst_ready_l2", 32'(ready_b), 32'd0);
    check("rst_rvalid_l1", {30'd0, rv_a1, rv_a2}, 32'd0);
    check("rst_rvalid_l2", {30'd0, rv_b1, rv_b2}, 32'd0);
    check("rst_rdata_a1", rd_a1, 32'd0);
    check("rst_rdata_a2", rd_a2, 32'd0);
    check("rst_rdata_b1", rd_b1, 32'd0);
    check("rst_rdata_b2", rd_b2, 32'd0);
    check("rst_collision", {30'd0, coll_a, coll_b}, 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    idle();
    flush();
    repeat (cycles) @(posedge clock);
    #1;
    reset_checks();
    reset = 1'b0;
  endtask

  // Count edges until ready rises, offering requests that must all be dropped.
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    set_p1(1'b1, 1'b0, 7'h7F, 4'h0, 32'h0);
    set_p2(1'b1, 1'b1, 7'h00, 4'hF, 32'hFFFF_FFFF);
    while (!ready_a && n < 400) begin
      step();
      n++;
    end
    idle();
    check(tag, 32'(n), 32'd128);
    check({tag, "_l2_ready"}, 32'(ready_b), 32'd1);
    run_ok = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    wait_clear("clear_len");

    // Cleared array reads zero, including the word targeted during clear.
    set_p1(1'b1, 1'b0, 7'h7F, 4'h0, 32'h0);
    set_p2(1'b1, 1'b0, 7'h00, 4'h0, 32'h0);
    step();
    idle(); step();

    // Masked writes.
    set_p1(1'b1, 1'b1, 7'd5, 4'hF, 32'hDEAD_BEEF); step();
    set_p1(1'b1, 1'b1, 7'd5, 4'h5, 32'h1122_3344); step();
    idle();
    set_p2(1'b1, 1'b0, 7'd5, 4'h0, 32'h0); step();
    idle(); step();

    // Cross-port read-first with collision, then visibility on the next edge.
    set_p1(1'b1, 1'b1, 7'd9, 4'hF, 32'hAAAA_AAAA); step();
    set_p1(1'b1, 1'b1, 7'd9, 4'hF, 32'h5555_5555);
    set_p2(1'b1, 1'b0, 7'd9, 4'h0, 32'h0); step();
    idle();
    set_p1(1'b1, 1'b0, 7'd9, 4'h0, 32'h0); step();
    idle(); step();

    // Write-write conflict on addr 3 over a known background.
    set_p2(1'b1, 1'b1, 7'd3, 4'hF, 32'h2222_2222); step();
    set_p1(1'b1, 1'b1, 7'd3, 4'h3, 32'h1111_1111);
    set_p2(1'b1, 1'b1, 7'd3, 4'h6, 32'h2222_2222); step();
    set_p1(1'b1, 1'b0, 7'd3, 4'h0, 32'h0);
    set_p2(1'b1, 1'b0, 7'd3, 4'h0, 32'h0); step();
    idle(); step();

    // Same-address reads: no collision. Zero-mask write: no-op.
    set_p1(1'b1, 1'b0, 7'd5, 4'h0, 32'h0);
    set_p2(1'b1, 1'b0, 7'd5, 4'h0, 32'h0); step();
    idle();
    set_p1(1'b1, 1'b1, 7'd5, 4'h0, 32'hFFFF_FFFF); step();
    idle();
    set_p1(1'b1, 1'b0, 7'd5, 4'h0, 32'h0); step();
    idle(); step();

    // Back-to-back reads 0,1,2 after seeding them.
    for (int i = 0; i < 3; i++) begin
      set_p1(1'b1, 1'b1, AW'(i), 4'hF, 32'hC0DE_0000 + 32'(i)); step();
    end
    for (int i = 0; i < 3; i++) begin
      set_p1(1'b1, 1'b0, AW'(i), 4'h0, 32'h0); step();
    end
    idle(); repeat (3) step();

    // Random traffic on a narrow address window to provoke conflicts.
    for (int i = 0; i < 80; i++) begin
      set_p1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
             MW'($urandom_range(0, 15)), $urandom);
      set_p2(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
             MW'($urandom_range(0, 15)), $urandom);
      step();
    end
    idle(); repeat (3) step();

    // Reset with reads in flight, then a full clear.
    set_p1(1'b1, 1'b0, 7'd9, 4'h0, 32'h0);
    set_p2(1'b1, 1'b0, 7'd3, 4'h0, 32'h0); step();
    set_p1(1'b1, 1'b0, 7'd5, 4'h0, 32'h0);
    set_p2(1'b0, 1'b0, 7'd0, 4'h0, 32'h0); step();
    do_reset(2);
    wait_clear("clear_len_after_read_reset");

    // Reset 40 cycles into the clear; clear must restart from address 0.
    set_p1(1'b1, 1'b1, 7'd5, 4'hF, 32'h1234_5678); step();
    idle(); step();
    do_reset(2);
    repeat (40) step();
    do_reset(2);
    wait_clear("clear_len_after_midclear_reset");

    set_p1(1'b1, 1'b0, 7'd5, 4'h0, 32'h0);
    set_p2(1'b1, 1'b0, 7'd0, 4'h0, 32'h0); step();
    idle(); repeat (3) step();

    for (int i = 0; i < 4; i++) check($sformatf("sb_drain[%0d]", i), 32'(sbq[i].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
